qreverse: RTL and testbench



---
 rtl/qreverse_if.sv | 30 +++
 rtl/qreverse.sv | 119 +++++++++++
 tb/tb_qreverse.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/qreverse_if.sv
// qreverse_if: DTI valid/ready link pair around qreverse (input Queue side and output Queue side).
// slave is the qreverse side; master is the producer/consumer side.
interface qreverse_if #(
  parameter int unsigned DIN = 16
);
  logic           din_valid;
  logic           din_ready;
  logic [DIN-1:0] din_data;
  logic           dout_valid;
  logic           dout_ready;
  logic [DIN-1:0] dout_data;

  modport slave (
    input  din_valid,
    input  din_data,
    input  dout_ready,
    output din_ready,
    output dout_valid,
    output dout_data
  );

  modport master (
    output din_valid,
    output din_data,
    output dout_ready,
    input  din_ready,
    input  dout_valid,
    input  dout_data
  );
endinterface

// File: rtl/qreverse.sv
// qreverse: buffers one Queue transaction in a LIFO and re-emits its words last-first.
// Define QREVERSE_OVF_FLAG_EN to add the sticky overflow output port `ovf`.
module qreverse #(
  parameter  int unsigned DIN   = 16,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic      clk,
  input  logic      rst,
`ifdef QREVERSE_OVF_FLAG_EN
  output logic      ovf,
`endif
  qreverse_if.slave q
);

  localparam int unsigned PW = DIN - 1;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    S_FILL,
    S_DRAIN
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [PW-1:0] r_mem [DEPTH];

  logic          w_in_eot;
  logic [PW-1:0] w_in_payload;
  logic          w_last_slot;
  logic          w_cnt_is_one;
  logic [AW-1:0] w_wr_addr;
  logic [AW-1:0] w_rd_addr;
  logic          w_din_ready;
  logic          w_dout_valid;
  logic          w_wr_en;

  assign w_in_eot     = q.din_data[DIN-1];
  assign w_in_payload = q.din_data[PW-1:0];
  assign w_last_slot  = (r_cnt == CW'(DEPTH - 1));
  assign w_cnt_is_one = (r_cnt == CW'(1));
  assign w_wr_addr    = AW'(r_cnt);
  assign w_rd_addr    = AW'(r_cnt - CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FILL;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_din_ready  = 1'b0;
    w_dout_valid = 1'b0;
    w_wr_en      = 1'b0;
    case (r_state)
      S_FILL: begin
        w_din_ready = 1'b1;
        if (q.din_valid) begin
          w_wr_en   = 1'b1;
          w_cnt_nxt = r_cnt + CW'(1);
          // The DEPTH-th word closes the transaction even without eot.
          if (w_in_eot || w_last_slot) begin
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        w_dout_valid = 1'b1;
        if (q.dout_ready) begin
          w_cnt_nxt = r_cnt - CW'(1);
          if (w_cnt_is_one) begin
            w_state_nxt = S_FILL;
          end
        end
      end
      default: begin
        w_state_nxt = S_FILL;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Storage is deliberately not reset; cnt alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= w_in_payload;
    end
  end

  assign q.din_ready  = w_din_ready  & ~rst;
  assign q.dout_valid = w_dout_valid & ~rst;
  assign q.dout_data  = (r_state == S_DRAIN) ? {w_cnt_is_one, r_mem[w_rd_addr]} : '0;

`ifdef QREVERSE_OVF_FLAG_EN
  logic w_force_close;
  logic r_ovf;

  assign w_force_close = (r_state == S_FILL) && q.din_valid && w_last_slot && !w_in_eot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_force_close) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_qreverse.sv
// tb_qreverse: two qreverse instances (DEPTH 16 and DEPTH 4) checked against a queue-based
// reverse-per-transaction model, with directed packets followed by randomized traffic.
module tb_qreverse;

  logic        clk = 1'b0;
  logic        rst;
  logic        din_valid  [2];
  logic [15:0] din_data   [2];
  logic        dout_ready [2];
  logic        din_ready  [2];
  logic        dout_valid [2];
  logic [15:0] dout_data  [2];
  logic        stall_en   [2];
`ifdef QREVERSE_OVF_FLAG_EN
  logic        ovf        [2];
  logic        exp_ovf    [2];
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [14:0] pkt_q   [2][$];
  logic [15:0] exp_q   [2][$];
  logic [15:0] out_log [2][$];
  logic        hold      [2];
  logic [15:0] hold_data [2];

  qreverse_if #(.DIN(16)) bus16 ();
  qreverse_if #(.DIN(16)) bus4 ();

  assign bus16.din_valid  = din_valid[0];
  assign bus16.din_data   = din_data[0];
  assign bus16.dout_ready = dout_ready[0];
  assign din_ready[0]     = bus16.din_ready;
  assign dout_valid[0]    = bus16.dout_valid;
  assign dout_data[0]     = bus16.dout_data;

  assign bus4.din_valid   = din_valid[1];
  assign bus4.din_data    = din_data[1];
  assign bus4.dout_ready  = dout_ready[1];
  assign din_ready[1]     = bus4.din_ready;
  assign dout_valid[1]    = bus4.dout_valid;
  assign dout_data[1]     = bus4.dout_data;

  qreverse #(.DIN(16), .DEPTH(16)) u_dut16 (
    .clk (clk),
    .rst (rst),
`ifdef QREVERSE_OVF_FLAG_EN
    .ovf (ovf[0]),
`endif
    .q   (bus16)
  );

  qreverse #(.DIN(16), .DEPTH(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
`ifdef QREVERSE_OVF_FLAG_EN
    .ovf (ovf[1]),
`endif
    .q   (bus4)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
    end
  endtask

  function automatic int depth_of(input int u);
    return (u == 0) ? 16 : 4;
  endfunction

  // Reference: collect accepted payloads; a word with eot, or the DEPTH-th word, closes the
  // transaction, which is then expected back reversed with eot on the first-received word.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        check_eq($sformatf("u%0d.rst_din_ready", u), din_ready[u], 0);
        check_eq($sformatf("u%0d.rst_dout_valid", u), dout_valid[u], 0);
`ifdef QREVERSE_OVF_FLAG_EN
        check_eq($sformatf("u%0d.rst_ovf", u), ovf[u], 0);
        exp_ovf[u] = 1'b0;
`endif
        pkt_q[u].delete();
        exp_q[u].delete();
        hold[u] = 1'b0;
      end else begin
        check_eq($sformatf("u%0d.din_ready", u), din_ready[u], exp_q[u].size() == 0);
        check_eq($sformatf("u%0d.dout_valid", u), dout_valid[u], exp_q[u].size() != 0);
`ifdef QREVERSE_OVF_FLAG_EN
        check_eq($sformatf("u%0d.ovf", u), ovf[u], exp_ovf[u]);
`endif
        if (hold[u]) check_eq($sformatf("u%0d.stall_stable", u), dout_data[u], hold_data[u]);
        if (dout_valid[u] && exp_q[u].size() != 0) begin
          check_eq($sformatf("u%0d.dout_data", u), dout_data[u], exp_q[u][0]);
          if (dout_ready[u]) begin
            out_log[u].push_back(dout_data[u]);
            void'(exp_q[u].pop_front());
          end
        end
        hold[u]      = dout_valid[u] && !dout_ready[u];
        hold_data[u] = dout_data[u];
        if (din_valid[u] && din_ready[u]) begin
          pkt_q[u].push_back(din_data[u][14:0]);
          if (din_data[u][15] || pkt_q[u].size() == depth_of(u)) begin
`ifdef QREVERSE_OVF_FLAG_EN
            if (!din_data[u][15]) exp_ovf[u] = 1'b1;
`endif
            for (int i = pkt_q[u].size() - 1; i >= 0; i--) begin
              exp_q[u].push_back({(i == 0), pkt_q[u][i]});
            end
            pkt_q[u].delete();
          end
        end
      end
    end
  end

  initial begin
    dout_ready[0] = 1'b1;
    dout_ready[1] = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      for (int u = 0; u < 2; u++) begin
        dout_ready[u] = stall_en[u] ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
    end
  end

  task automatic send_word(input int u, input logic [15:0] w);
    int guard = 0;
    din_valid[u] = 1'b1;
    din_data[u]  = w;
    forever begin
      @(negedge clk);
      if (din_ready[u]) break;
      guard++;
      if (guard > 500) begin
        check_eq($sformatf("u%0d.send_timeout", u), din_ready[u], 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    din_valid[u] = 1'b0;
  endtask

  task automatic wait_idle(input int u, input string tag);
    int n = 0;
    while ((exp_q[u].size() != 0 || !din_ready[u]) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq({tag, ".drained"}, exp_q[u].size(), 0);
    check_eq({tag, ".ready_back"}, din_ready[u], 1);
  endtask

  task automatic check_log(input string tag, input int u, input logic [15:0] want [$]);
    check_eq({tag, ".count"}, out_log[u].size(), want.size());
    for (int i = 0; i < want.size() && i < out_log[u].size(); i++) begin
      check_eq($sformatf("%s.word%0d", tag, i), out_log[u][i], want[i]);
    end
    out_log[u].delete();
  endtask

  task automatic rand_traffic(input int u);
    for (int k = 0; k < 60; k++) begin
      send_word(u, {($urandom_range(0, 4) == 0), 15'($urandom)});
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    send_word(u, {1'b1, 15'($urandom)});
    wait_idle(u, $sformatf("u%0d.rand", u));
  endtask

  initial begin
    logic [15:0] want [$];
    logic [14:0] pa, pb, pc;
    for (int u = 0; u < 2; u++) begin
      din_valid[u] = 1'b0;
      din_data[u]  = '0;
      stall_en[u]  = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    send_word(0, 16'h0001);
    send_word(0, 16'h0002);
    send_word(0, 16'h0003);
    send_word(0, 16'h8004);
    wait_idle(0, "basic");
    want = '{16'h0004, 16'h0003, 16'h0002, 16'h8001};
    check_log("basic", 0, want);

    send_word(0, 16'h8055);
    wait_idle(0, "single");
    want = '{16'h8055};
    check_log("single", 0, want);

    pa = 15'($urandom);
    pb = 15'($urandom);
    pc = 15'($urandom);
    stall_en[0] = 1'b1;
    send_word(0, {1'b0, pa});
    send_word(0, {1'b0, pb});
    send_word(0, {1'b1, pc});
    wait_idle(0, "backpressure");
    stall_en[0] = 1'b0;
    want = '{{1'b0, pc}, {1'b0, pb}, {1'b1, pa}};
    check_log("backpressure", 0, want);

`ifdef QREVERSE_OVF_FLAG_EN
    check_eq("ovf_before", ovf[1], 0);
`endif
    for (int i = 1; i <= 5; i++) send_word(1, 16'(i));
    send_word(1, 16'h8006);
    wait_idle(1, "overflow");
    want = '{16'h0004, 16'h0003, 16'h0002, 16'h8001, 16'h0006, 16'h8005};
    check_log("overflow", 1, want);
`ifdef QREVERSE_OVF_FLAG_EN
    check_eq("ovf_sticky", ovf[1], 1);
`endif

    send_word(0, 16'h0007);
    send_word(0, 16'h8008);
    send_word(0, 16'h8009);
    wait_idle(0, "b2b");
    want = '{16'h0008, 16'h8007, 16'h8009};
    check_log("b2b", 0, want);

    send_word(0, 16'h000A);
    send_word(0, 16'h000B);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    send_word(0, 16'h800C);
    wait_idle(0, "rst_mid");
    want = '{16'h800C};
    check_log("rst_mid", 0, want);

    stall_en[0] = 1'b1;
    stall_en[1] = 1'b1;
    fork
      rand_traffic(0);
      rand_traffic(1);
    join
    stall_en[0] = 1'b0;
    stall_en[1] = 1'b0;

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
